// File: rtl/cam_capture.sv
// cam_capture
//   Camera capture stage. Oversamples the camera pins (PCLK, VSYNC, HREF,
//   D[7:0]) on clk and packs byte pairs into 8-bit pixels. Writes one frame
//   of H_PIX x V_LINES pixels linearly into the frame-buffer write port.
//
//   Optional build macro: CAM_TEST_PATTERN_EN
//     defined   : cam_d is ignored and wr_data carries 8 colour bars per line.
//                 All timing still comes from the camera.
//     undefined : wr_data = {hi[7:5], hi[2:0], lo[4:3]}.
//
// Ports
//   clk        in   system clock (>= 4x cam_pclk)
//   rst        in   asynchronous reset, active-low
//   en_cap     in   block enable; low returns to IDLE and clears counters
//   start      in   one-cycle request to capture the next full frame
//   cam_pclk   in   camera pixel clock (asynchronous)
//   cam_vsync  in   camera VSYNC, high = vertical blank
//   cam_href   in   camera HREF, high = valid bytes
//   cam_d      in   camera data byte
//   wr_en      out  frame-buffer write strobe, one cycle per pixel
//   wr_addr    out  frame-buffer write address
//   wr_data    out  RGB332 pixel
//   busy       out  high while armed or capturing
//   frame_done out  one-cycle pulse at the end of a captured frame
//   overflow   out  sticky: pixels beyond H_PIX*V_LINES arrived in this frame
module cam_capture #(
  parameter int unsigned H_PIX   = 160,
  parameter int unsigned V_LINES = 120,
  parameter int unsigned AW      = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_cap,
  input  logic          start,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_d,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow
);

  // Pixel counter carries one extra bit so it can hold H_PIX*V_LINES even
  // when the frame exactly fills the address space.
  localparam logic [AW:0] TOTAL = (AW+1)'(H_PIX * V_LINES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic       pclk_m, pclk_s, pclk_p;
  logic       vs_m, vs_s, vs_p;
  logic       href_m, href_s, href_p;
  logic [7:0] d_m, d_s;

  logic       pclk_rise, vs_rise, vs_fall, href_fall;
  logic       cap_entry;
  logic       phase;
  logic [5:0] hi;
  logic [AW:0] pix_cnt;
  logic [7:0] pixel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_m <= 1'b0; pclk_s <= 1'b0; pclk_p <= 1'b0;
      vs_m   <= 1'b0; vs_s   <= 1'b0; vs_p   <= 1'b0;
      href_m <= 1'b0; href_s <= 1'b0; href_p <= 1'b0;
      d_m    <= '0;   d_s    <= '0;
    end else begin
      pclk_m <= cam_pclk;  pclk_s <= pclk_m; pclk_p <= pclk_s;
      vs_m   <= cam_vsync; vs_s   <= vs_m;   vs_p   <= vs_s;
      href_m <= cam_href;  href_s <= href_m; href_p <= href_s;
      d_m    <= cam_d;     d_s    <= d_m;
    end
  end

  assign pclk_rise = pclk_s & ~pclk_p;
  assign vs_rise   = vs_s & ~vs_p;
  assign vs_fall   = ~vs_s & vs_p;
  assign href_fall = ~href_s & href_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_entry = 1'b0;
    if (!en_cap) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_ARM;
        S_ARM:     if (vs_fall) begin
                     state_nxt = S_CAPTURE;
                     cap_entry = 1'b1;
                   end
        S_CAPTURE: if (vs_rise) state_nxt = S_DONE;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy       = (state == S_ARM) || (state == S_CAPTURE);
  assign frame_done = (state == S_DONE);
  assign wr_addr    = pix_cnt[AW-1:0];

`ifdef CAM_TEST_PATTERN_EN
  localparam logic [AW:0] COLS = (AW+1)'(H_PIX);
  localparam logic [AW:0] BARW = (AW+1)'(H_PIX / 8);
  logic [AW:0] tp_col, tp_bar;
  assign tp_col = pix_cnt % COLS;
  assign tp_bar = tp_col / BARW;
  assign pixel  = {{3{tp_bar[2]}}, {3{tp_bar[1]}}, {2{tp_bar[0]}}};
`else
  assign pixel  = {hi[5:3], hi[2:0], d_s[4:3]};
`endif

  // Only the hi-byte bits that reach the pixel are kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      overflow <= 1'b0;
      phase    <= 1'b0;
      hi       <= '0;
      pix_cnt  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (!en_cap) begin
        pix_cnt <= '0;
        phase   <= 1'b0;
      end else if (cap_entry) begin
        pix_cnt  <= '0;
        phase    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) pix_cnt <= pix_cnt + 1'b1;
        // A vs_rise in the same cycle as a byte discards that byte.
        if (state == S_CAPTURE && !vs_rise) begin
          if (href_fall) begin
            phase <= 1'b0;
          end else if (pclk_rise && href_s) begin
            if (!phase) begin
              hi    <= {d_s[7:5], d_s[2:0]};
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (pix_cnt < TOTAL) begin
                wr_en   <= 1'b1;
                wr_data <= pixel;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;
  localparam int unsigned H   = 16;
  localparam int unsigned V   = 6;
  localparam int unsigned AW  = 7;
  localparam int unsigned CAP = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_cap;
  logic          start;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  cam_capture #(.H_PIX(H), .V_LINES(V), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en_cap(en_cap), .start(start),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: cumulative logs, sampled on the falling edge.
  logic [AW-1:0] got_addr[$];
  logic [7:0]    got_data[$];
  int            done_total = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wr_en === 1'b1) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (frame_done === 1'b1) done_total++;
    end
  end

  // Reference model: expected pixel stream of the current frame.
  logic [7:0] exp_q[$];
  bit         exp_ovf;
  int         base;
  int         done_base;

  task automatic begin_frame();
    exp_q.delete();
    exp_ovf   = 1'b0;
    base      = got_addr.size();
    done_base = done_total;
  endtask

  task automatic pclk_cycle();
    #25 cam_pclk = 1'b1;
    #25 cam_pclk = 1'b0;
  endtask

  // Bytes pair up from the start of every line; an odd trailing byte is lost.
  task automatic send_line(input int n);
    logic [7:0] b, hb;
    bit have;
    have = 1'b0;
    hb   = '0;
    cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      cam_d = b;
      pclk_cycle();
      if (!have) begin
        hb   = b;
        have = 1'b1;
      end else begin
        have = 1'b0;
        if (exp_q.size() < CAP) exp_q.push_back({hb[7:5], hb[2:0], b[4:3]});
        else                    exp_ovf = 1'b1;
      end
    end
    cam_href = 1'b0;
    cam_d    = 8'($urandom);
    repeat (3) pclk_cycle();
  endtask

  task automatic frame(input int nlines, input int first_len, input int minlen, input int maxlen);
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle();
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle();
    for (int l = 0; l < nlines; l++) begin
      if (l == 0 && first_len > 0) send_line(first_len);
      else                         send_line(int'($urandom_range(minlen, maxlen)));
    end
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int n;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n = got_addr.size() - base;
    chk({tag, "_writes"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(got_addr[base+i]), 32'(i));
      chk({tag, "_data"}, 32'(got_data[base+i]), 32'(exp_q[i]));
    end
    chk({tag, "_done"}, 32'(done_total - done_base), 32'd1);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n0;
    rst = 1'b0; en_cap = 1'b1; start = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); cam_pclk = 1'($urandom); cam_vsync = 1'($urandom);
      cam_href = 1'($urandom); cam_d = 8'($urandom);
      @(negedge clk);
      chk("rst_outs", {20'd0, wr_en, busy, frame_done, overflow, wr_data},
          32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
    end
    start = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Start while vsync low: armed, waits for the next vsync fall
    begin_frame();
    pulse_start();
    repeat (30) @(negedge clk);
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_nowrite", 32'(got_addr.size() - base), 32'd0);
    // Full frame, with a start pulse during capture that must be ignored
    fork
      frame(V, 0, 2*H, 2*H);
      begin #3000; pulse_start(); end
    join
    check_frame("full");

    // Overflow: one extra line
    begin_frame();
    pulse_start();
    frame(V + 1, 0, 2*H, 2*H);
    check_frame("ovf");

    // Odd/ragged line lengths, first line of 5 bytes
    begin_frame();
    pulse_start();
    frame(V, 5, 1, 2*H + 1);
    check_frame("odd");

    // en_cap dropped mid-line
    begin_frame();
    pulse_start();
    cam_vsync = 1'b1; repeat (4) pclk_cycle();
    cam_vsync = 1'b0; repeat (3) pclk_cycle();
    send_line(8);
    cam_href = 1'b1; cam_d = 8'($urandom); pclk_cycle();
    @(posedge clk); #1 en_cap = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("dis_busy", 32'(busy), 32'd0);
    n0 = got_addr.size() - base;
    chk("dis_before", 32'(n0), 32'd4);
    for (int i = 0; i < 9; i++) begin cam_d = 8'($urandom); pclk_cycle(); end
    cam_href = 1'b0;
    cam_vsync = 1'b1; repeat (4) pclk_cycle();
    repeat (5) @(negedge clk);
    chk("dis_nowrite", 32'(got_addr.size() - base), 32'(n0));
    chk("dis_nodone", 32'(done_total - done_base), 32'd0);
    chk("dis_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 en_cap = 1'b1;

    // Fresh frame after re-enable starts from address 0
    begin_frame();
    pulse_start();
    frame(V, 0, 2*H - 4, 2*H);
    check_frame("reen");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
